// File: rtl/dmul_uni_sched_if.sv
// Requester-side and response-side handshake bundle for dmul_uni_sched.
// Operands are packed per requester: requester i owns bits [i*INWD +: INWD].
interface dmul_uni_sched_if #(
  parameter int INWD = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*INWD-1:0] req_a;
  logic [NREQ*INWD-1:0] req_b;
  logic [2*INWD-1:0]    cfg_len;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [2*INWD-1:0]    rsp_data;

  // Requester fabric / response consumer side
  modport master (
    output req_valid, req_a, req_b, cfg_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_a, req_b, cfg_len, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/dmul_uni_sched.sv
// Round-robin front end for a single shared unary multiplier: grants one
// requester at a time, pulses the multiplier load, runs the bitstream for the
// programmed length, then returns the captured product tagged with the id.
module dmul_uni_sched #(
  parameter int INWD = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmul_uni_sched_if.slave   bus,
  output logic [INWD-1:0]   mul_iA_o,
  output logic [INWD-1:0]   mul_iB_o,
  output logic              mul_loadA_o,
  output logic              mul_loadB_o,
  input  logic [2*INWD-1:0] mul_oC_i,
  output logic              busy_o
);
  localparam int RW = 2 * INWD;  // result width
  localparam int CW = RW + 1;    // count width; holds 2^RW without wrapping

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q;
  logic [INWD-1:0] a_q, b_q;
  logic [CW-1:0]   len_q, cnt_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [RW-1:0]   rsp_data_q;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  idx;
  logic            run_last;

  assign run_last = (cnt_q == len_q - CW'(1));

  // First set req_valid searching upward from ptr, wrapping modulo NREQ
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_vld && bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  // Accept strobe: only in IDLE and never while reset is held
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state_q == IDLE && gnt_vld) bus.req_ready[gnt_id] = 1'b1;
  end

  // Next-state and pointer update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (gnt_vld) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN:  if (run_last) state_d = RESP;
      RESP: if (bus.rsp_ready) begin
              state_d = IDLE;
              ptr_d   = IDW'((int'(id_q) + 1) % NREQ);
            end
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Operand latch at accept, run counter, result capture and hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_vld) begin
                a_q   <= bus.req_a[int'(gnt_id)*INWD +: INWD];
                b_q   <= bus.req_b[int'(gnt_id)*INWD +: INWD];
                id_q  <= gnt_id;
                // zero length encodes the full 2^RW-cycle run
                len_q <= (bus.cfg_len == '0) ? (CW'(1) << RW) : CW'(bus.cfg_len);
              end
        LOAD: cnt_q <= '0;
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (run_last) begin
            rsp_data_q  <= mul_oC_i;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mul_iA_o     = a_q;
  assign mul_iB_o     = b_q;
  assign mul_loadA_o  = (state_q == LOAD);
  assign mul_loadB_o  = (state_q == LOAD);
  assign busy_o       = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_dmul_uni_sched.sv
// Scoreboard bench for dmul_uni_sched. The multiplier is a stub whose oC is
// iA*iB plus the number of cycles since load, so the captured value encodes
// both the operands routed and the exact capture cycle: expected = a*b + L.
module tb_dmul_uni_sched;
  localparam int INWD = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmul_uni_sched_if #(.INWD(INWD), .NREQ(NREQ), .IDW(IDW)) bus ();

  logic [INWD-1:0]   mul_iA, mul_iB;
  logic              mul_loadA, mul_loadB, busy;
  logic [2*INWD-1:0] mul_oC;

  dmul_uni_sched #(.INWD(INWD), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mul_iA_o(mul_iA), .mul_iB_o(mul_iB),
    .mul_loadA_o(mul_loadA), .mul_loadB_o(mul_loadB),
    .mul_oC_i(mul_oC), .busy_o(busy)
  );

  // Multiplier stub
  logic [16:0] k_q;
  always @(posedge clk) begin
    if (!rst_n)         k_q <= '0;
    else if (mul_loadA) k_q <= 17'd1;
    else                k_q <= k_q + 17'd1;
  end
  assign mul_oC = 16'(16'(mul_iA) * 16'(mul_iB) + k_q[15:0]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- requester driver ----------------
  typedef struct { logic [7:0] a; logic [7:0] b; int life; } op_t;
  op_t  pq [NREQ][$];
  op_t  cur [NREQ];
  int   age [NREQ];
  logic [NREQ-1:0] hs;
  int   rr_mode = 0;  // 0: always ready, 1: random, 2: held low

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) age[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && (hs[i] || (cur[i].life != 0 && age[i] >= cur[i].life)))
          bus.req_valid[i] = 1'b0;
        else if (bus.req_valid[i])
          age[i]++;
        if (!bus.req_valid[i] && pq[i].size() > 0) begin
          cur[i] = pq[i].pop_front();
          bus.req_a[i*INWD +: INWD] = cur[i].a;
          bus.req_b[i*INWD +: INWD] = cur[i].b;
          bus.req_valid[i] = 1'b1;
          age[i] = 0;
        end
      end
      case (rr_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  typedef struct { int id; logic [15:0] data; int due; } exp_t;
  exp_t sbq[$];
  int   mptr;
  bit   midle = 1'b1;
  bit   in_op, rsp_seen;
  int   load_due = -1;
  logic [7:0]  ca, cb;
  logic [15:0] held_data;
  int   held_id;

  always begin
    int g, idx, len;
    exp_t e;
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    if (!rst_n) begin
      chk("ready_in_reset", bus.req_ready, 0);
      sbq.delete();
      mptr = 0; midle = 1'b1; in_op = 1'b0; rsp_seen = 1'b0; load_due = -1;
    end else begin
      chk("busy", busy, !midle);
      if (midle) begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (mptr + k) % NREQ;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
        chk("req_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
        if (g >= 0) begin
          ca  = bus.req_a[g*INWD +: INWD];
          cb  = bus.req_b[g*INWD +: INWD];
          len = (bus.cfg_len == 0) ? 65536 : int'(bus.cfg_len);
          e.id   = g;
          e.data = 16'((int'(ca) * int'(cb) + len) % 65536);
          e.due  = cyc + len + 2;
          sbq.push_back(e);
          midle = 1'b0; in_op = 1'b1; load_due = cyc + 1;
        end
      end else begin
        chk("ready_while_busy", bus.req_ready, 0);
      end
      chk("loadA", mul_loadA, cyc == load_due);
      chk("loadB", mul_loadB, cyc == load_due);
      if (in_op && cyc >= load_due) begin
        chk("mul_iA", mul_iA, ca);
        chk("mul_iB", mul_iB, cb);
      end
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          if (!rsp_seen) begin
            chk("rsp_time", cyc, sbq[0].due);
            chk("rsp_id", bus.rsp_id, sbq[0].id);
            chk("rsp_data", bus.rsp_data, sbq[0].data);
            held_id = int'(bus.rsp_id); held_data = bus.rsp_data; rsp_seen = 1'b1;
          end else begin
            chk("rsp_id_hold", bus.rsp_id, held_id);
            chk("rsp_data_hold", bus.rsp_data, held_data);
          end
          if (bus.rsp_ready) begin
            mptr = (sbq[0].id + 1) % NREQ;
            void'(sbq.pop_front());
            midle = 1'b1; in_op = 1'b0; rsp_seen = 1'b0;
          end
        end
      end else if (sbq.size() > 0 && cyc == sbq[0].due) begin
        chk("rsp_late", bus.rsp_valid, 1);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic bit all_quiet();
    for (int i = 0; i < NREQ; i++) if (pq[i].size() > 0) return 1'b0;
    return (bus.req_valid == '0) && (sbq.size() == 0) && !busy;
  endfunction

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (!all_quiet() && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) chk("drain_timeout", sbq.size(), 0);
  endtask

  task automatic push(input int r, input int a, input int b, input int life);
    op_t o;
    o.a = 8'(a); o.b = 8'(b); o.life = life;
    pq[r].push_back(o);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({nm, "_rsp_id"},    bus.rsp_id, 0);
    chk({nm, "_rsp_data"},  bus.rsp_data, 0);
    chk({nm, "_iA"},        mul_iA, 0);
    chk({nm, "_iB"},        mul_iB, 0);
    chk({nm, "_load"},      {mul_loadA, mul_loadB}, 0);
    chk({nm, "_busy"},      busy, 0);
  endtask

  // Wait (bounded) for an accept; returns its cycle, or -1 on timeout
  task automatic wait_accept(output int t);
    int n;
    n = 0; t = -1;
    while (n < 2000) begin
      @(negedge clk);
      if ((bus.req_valid & bus.req_ready) != '0) begin t = cyc; break; end
      n++;
    end
    if (t < 0) chk("accept_timeout", bus.req_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    bus.cfg_len = 16'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    chk("reset_ready", bus.req_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // full-length run (cfg_len 0 => 65536 cycles)
    bus.cfg_len = 16'd0;
    push(0, 128, 128, 0);
    drain(70000);

    // short capture timing
    bus.cfg_len = 16'd5;
    push(1, 3, 7, 0);
    drain(200);

    // round robin: bring ptr to 0, then all four requesting, cfg_len 1
    bus.cfg_len = 16'd1;
    push(3, 9, 9, 0);
    drain(200);
    push(0, 11, 12, 0); push(0, 21, 22, 0);
    push(1, 13, 14, 0); push(2, 15, 16, 0); push(3, 17, 18, 0);
    drain(500);
    // ptr now 1: requesters 2 and 0 raised together, 2 must win
    push(2, 250, 3, 0); push(0, 5, 250, 0);
    drain(300);

    // backpressure with a pending request and a requester that gives up
    rr_mode = 2;
    bus.cfg_len = 16'd3;
    push(1, 200, 201, 0);
    wait_accept(t);
    push(3, 77, 66, 0);
    push(0, 1, 2, 4);
    repeat (30) @(posedge clk);
    rr_mode = 0;
    drain(300);

    // reset mid-RUN at cnt == 100
    bus.cfg_len = 16'd300;
    push(2, 99, 98, 0);
    wait_accept(t);
    if (t >= 0) begin
      while (cyc < t + 102) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk_zero("mid_run_reset");
    end
    bus.cfg_len = 16'd4;
    push(1, 40, 50, 0);
    drain(300);

    // cfg_len changed during RUN must not affect the running op
    bus.cfg_len = 16'd10;
    push(0, 123, 45, 0);
    wait_accept(t);
    @(posedge clk); #2 bus.cfg_len = 16'd2;
    drain(300);

    // randomized traffic with random backpressure
    rr_mode = 1;
    for (int n = 0; n < 40; n++) begin
      push($urandom_range(0, NREQ-1), $urandom_range(0, 255), $urandom_range(0, 255),
           ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0);
      repeat ($urandom_range(0, 8)) @(posedge clk);
      #2 bus.cfg_len = 16'($urandom_range(1, 12));
    end
    drain(10000);
    rr_mode = 0;
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
